// File: rtl/traffic_seq_ctrl.sv
// Four-phase traffic-light sequencer with a loadable per-phase down-counter.
// Consumes the divider tick as count enable; all outputs are registered.
module traffic_seq_ctrl #(
  parameter int unsigned T_NSG = 9,
  parameter int unsigned T_NSY = 2,
  parameter int unsigned T_EWG = 7,
  parameter int unsigned T_EWY = 2
) (
  input  logic       cp,
  input  logic       clr,
  input  logic       tick,
  input  logic       hold,
  input  logic       ped,
  output logic [1:0] phase,
  output logic [3:0] Q,
  output logic       qcc,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light
);

  typedef enum logic [1:0] {
    NSG = 2'd0,
    NSY = 2'd1,
    EWG = 2'd2,
    EWY = 2'd3
  } phase_t;

  localparam logic [3:0] D_NSG = 4'(T_NSG);
  localparam logic [3:0] D_NSY = 4'(T_NSY);
  localparam logic [3:0] D_EWG = 4'(T_EWG);
  localparam logic [3:0] D_EWY = 4'(T_EWY);

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  phase_t state;

  function automatic phase_t next_of(input phase_t p);
    case (p)
      NSG:     next_of = NSY;
      NSY:     next_of = EWG;
      EWG:     next_of = EWY;
      default: next_of = NSG;
    endcase
  endfunction

  function automatic logic [3:0] dur_of(input phase_t p);
    case (p)
      NSG:     dur_of = D_NSG;
      NSY:     dur_of = D_NSY;
      EWG:     dur_of = D_EWG;
      default: dur_of = D_EWY;
    endcase
  endfunction

  function automatic logic [2:0] ns_of(input phase_t p);
    case (p)
      NSG:     ns_of = L_GRN;
      NSY:     ns_of = L_YEL;
      default: ns_of = L_RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_of(input phase_t p);
    case (p)
      EWG:     ew_of = L_GRN;
      EWY:     ew_of = L_YEL;
      default: ew_of = L_RED;
    endcase
  endfunction

  // Lights are registered alongside the phase so they always agree with it.
  always_ff @(posedge cp or negedge clr) begin
    if (!clr) begin
      state    <= NSG;
      Q        <= D_NSG;
      qcc      <= 1'b0;
      ns_light <= L_GRN;
      ew_light <= L_RED;
    end else begin
      qcc <= 1'b0;
      if (!hold) begin
        if (ped && (state == NSG || state == EWG) && Q > 4'd3) begin
          Q <= 4'd3;
        end else if (tick) begin
          if (Q > 4'd1) begin
            Q <= Q - 4'd1;
          end else begin
            state    <= next_of(state);
            Q        <= dur_of(next_of(state));
            qcc      <= 1'b1;
            ns_light <= ns_of(next_of(state));
            ew_light <= ew_of(next_of(state));
          end
        end
      end
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_seq_ctrl.sv
// Self-checking bench: two sequencers (defaults and a 1-tick NS yellow) share
// stimulus and are compared every cycle against a phase/remaining-time model.
module tb_traffic_seq_ctrl;

  logic cp = 1'b0;
  logic clr = 1'b1;
  logic tick = 1'b0;
  logic hold = 1'b0;
  logic ped = 1'b0;

  logic [1:0] pa, pb;
  logic [3:0] qa, qb;
  logic       ca, cb;
  logic [2:0] nsa, ewa, nsb, ewb;

  int checks = 0;
  int errors = 0;
  bit en = 1'b0;

  traffic_seq_ctrl dut_a (
    .cp(cp), .clr(clr), .tick(tick), .hold(hold), .ped(ped),
    .phase(pa), .Q(qa), .qcc(ca), .ns_light(nsa), .ew_light(ewa)
  );

  traffic_seq_ctrl #(.T_NSY(1)) dut_b (
    .cp(cp), .clr(clr), .tick(tick), .hold(hold), .ped(ped),
    .phase(pb), .Q(qb), .qcc(cb), .ns_light(nsb), .ew_light(ewb)
  );

  always #5 cp = ~cp;

  // Behavioural model: a phase index, seconds remaining, and a transition flag.
  int dur_a [4] = '{9, 2, 7, 2};
  int dur_b [4] = '{9, 1, 7, 2};
  int ns_tab [4] = '{1, 2, 4, 4};
  int ew_tab [4] = '{4, 4, 1, 2};
  int ma_ph, ma_q, mb_ph, mb_q;
  bit ma_c, mb_c;

  task automatic model_step(input int dur [4], inout int ph, inout int q, output bit c);
    c = 1'b0;
    if (!hold) begin
      if (ped && (ph % 2 == 0) && q > 3) q = 3;
      else if (tick) begin
        if (q > 1) q = q - 1;
        else begin
          ph = (ph + 1) % 4;
          q  = dur[ph];
          c  = 1'b1;
        end
      end
    end
  endtask

  always @(posedge cp or negedge clr) begin
    if (!clr) begin
      ma_ph = 0; ma_q = dur_a[0]; ma_c = 1'b0;
      mb_ph = 0; mb_q = dur_b[0]; mb_c = 1'b0;
    end else begin
      model_step(dur_a, ma_ph, ma_q, ma_c);
      model_step(dur_b, mb_ph, mb_q, mb_c);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge cp) begin
    if (en) begin
      chk("A.phase", int'(pa), ma_ph);
      chk("A.Q", int'(qa), ma_q);
      chk("A.qcc", int'(ca), int'(ma_c));
      chk("A.ns", int'(nsa), ns_tab[ma_ph]);
      chk("A.ew", int'(ewa), ew_tab[ma_ph]);
      chk("B.phase", int'(pb), mb_ph);
      chk("B.Q", int'(qb), mb_q);
      chk("B.qcc", int'(cb), int'(mb_c));
      chk("B.ns", int'(nsb), ns_tab[mb_ph]);
      chk("B.ew", int'(ewb), ew_tab[mb_ph]);
    end
  end

  task automatic cyc(input bit t, input bit p, input bit h);
    tick = t; ped = p; hold = h;
    @(negedge cp);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic async_reset_check(input string tag);
    #2 clr = 1'b0;
    #1;
    chk({tag, ".rst.phase"}, int'(pa), 0);
    chk({tag, ".rst.Q"}, int'(qa), 9);
    chk({tag, ".rst.qcc"}, int'(ca), 0);
    chk({tag, ".rst.ns"}, int'(nsa), 1);
    chk({tag, ".rst.ew"}, int'(ewa), 4);
    chk({tag, ".rst.Bq"}, int'(qb), 9);
    @(negedge cp);
    tick = 1'b0; ped = 1'b0; hold = 1'b0;
    clr = 1'b1;
  endtask

  initial begin
    int npulse;
    #1 clr = 1'b0;
    #1;
    chk("rst.phase", int'(pa), 0);
    chk("rst.Q", int'(qa), 9);
    chk("rst.qcc", int'(ca), 0);
    chk("rst.ns", int'(nsa), 1);
    chk("rst.ew", int'(ewa), 4);
    chk("rst.model_q", ma_q, 9);
    @(negedge cp);
    @(negedge cp);
    clr = 1'b1;
    en = 1'b1;
    @(negedge cp);

    // Free run: tick every 4 cycles, 20 ticks = one full cycle of phases.
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (ca) npulse++;
      if (i == 8) begin
        chk("free.nsy_phase", int'(pa), 1);
        chk("free.nsy_q", int'(qa), 2);
      end
      for (int k = 0; k < 3; k++) begin
        cyc(1'b0, 1'b0, 1'b0);
        if (ca) npulse++;
      end
    end
    chk("free.qcc_pulses", npulse, 4);
    chk("free.back_phase", int'(pa), 0);
    chk("free.back_q", int'(qa), 9);

    // Shorten green with ped coincident with tick.
    ticks(1);
    chk("short.q8", int'(qa), 8);
    cyc(1'b1, 1'b1, 1'b0);
    chk("short.q3", int'(qa), 3);
    ticks(3);
    chk("short.nsy", int'(pa), 1);
    chk("short.qcc", int'(ca), 1);

    // ped in yellow has no effect.
    cyc(1'b0, 1'b1, 1'b0);
    chk("noop.nsy_q", int'(qa), 2);
    chk("noop.nsy_ph", int'(pa), 1);
    ticks(2);
    chk("ewg.q7", int'(qa), 7);
    ticks(2);

    // Hold in EWG with Q=5: ticks and ped are discarded.
    for (int i = 0; i < 7; i++) begin
      cyc(i != 3, i == 3, 1'b1);
      chk("hold.q", int'(qa), 5);
      chk("hold.ph", int'(pa), 2);
      chk("hold.qcc", int'(ca), 0);
    end
    ticks(1);
    chk("hold.release_q", int'(qa), 4);
    ticks(1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("noop.ewg_q3", int'(qa), 3);
    ticks(4);
    chk("ewy.q1_ph", int'(pa), 3);
    chk("ewy.q1", int'(qa), 1);
    async_reset_check("mid");
    @(negedge cp);

    // ped held high for 10 cycles in NSG with Q=9.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk("pedhold.q", int'(qa), 3);
    end
    ticks(1);
    chk("pedhold.after", int'(qa), 2);
    async_reset_check("r2");
    @(negedge cp);

    // One-tick NS yellow: consecutive ticks give back-to-back qcc on B.
    ticks(8);
    chk("b.q1", int'(qb), 1);
    ticks(1);
    chk("b.nsy_ph", int'(pb), 1);
    chk("b.nsy_q", int'(qb), 1);
    chk("b.qcc1", int'(cb), 1);
    ticks(1);
    chk("b.ewg_ph", int'(pb), 2);
    chk("b.ewg_q", int'(qb), 7);
    chk("b.qcc2", int'(cb), 1);

    // Randomized traffic with occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 399) == 0) async_reset_check("rnd");
    end

    tick = 1'b0; ped = 1'b0; hold = 1'b0;
    @(negedge cp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
